led_scanner: RTL
================

# led_scanner

Parametrised LED scanner: drives WIDTH LED outputs with a moving single-lit position. The position advances one step every PRESCALE clock cycles. It sits between the top level and the pmod LED drivers and replaces hand-written scanner logic in the top level. It supports three movement modes, a hold mode and an enable input, and has an optional fading trail rendered by PWM.

## Interface
- WIDTH, 16: number of LED outputs; must be ≥ 2.
- PRESCALE, 300000: clock cycles per step; must be ≥ 1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  when 0 the prescaler is frozen and no steps occur.
- mode  in  2  movement mode: 0 = BOUNCE, 1 = ROT_UP, 2 = ROT_DOWN, 3 = HOLD.
- leds  out  WIDTH  LED drive; bit i lit = 1.
- pos  out  $clog2(WIDTH)  current lit index.
- dir  out  1  bounce direction; 1 = up (toward WIDTH-1).
- step  out  1  one-cycle pulse on each applied step.

## Operation
- Prescaler `cnt`:
  - Width is $clog2(PRESCALE) bits, minimum 1.
  - When en=1: if cnt==0, assert step and reload cnt to PRESCALE-1; otherwise decrement cnt.
  - When en=0: cnt holds and step=0.
- On step, pos/dir update according to the mode sampled in that cycle:
  - BOUNCE, dir=1: if pos==WIDTH-1 then dir←0 and pos←WIDTH-2; else pos←pos+1.
  - BOUNCE, dir=0: if pos==0 then dir←1 and pos←1; else pos←pos-1.
  - BOUNCE consequence: each end index is lit for exactly one step period, and there is no double-dwell at the ends.
  - ROT_UP: pos←(pos==WIDTH-1) ? 0 : pos+1. dir is unchanged.
  - ROT_DOWN: pos←(pos==0) ? WIDTH-1 : pos-1. dir is unchanged.
  - HOLD: pos and dir are unchanged; step still pulses.
- Mode changes take effect only at the next step. Switching from a rotate mode back to BOUNCE resumes in the stored dir.
- Without trail, leds = one-hot(pos), decoded from the registered pos.

## Timing
- Reset values: cnt=PRESCALE-1, pos=0, dir=1, step=0, leds=1 (bit 0 lit). With trail enabled, leds[0]=1 and all other bits are 0.
- First step is asserted PRESCALE cycles after rst deasserts, provided en=1 throughout.
- Steps then recur every PRESCALE cycles.
- pos, dir and leds change on the same edge that ends the step-high cycle.
- en=0 mid-count: the count resumes from the held value. Latency to the next step is extended by exactly the number of disabled cycles.
- rst asserted mid-operation: all state returns to reset values on that edge. rst has priority over en and step.
- PRESCALE=1: step is high on every cycle while en=1.

## Configuration
- `LED_SCANNER_TRAIL_EN` defined:
  - Each LED has a 4-bit level register. On reset, level[0]=15 and all other levels are 0.
  - On step, level[new pos]←15 and every other level←level>>1.
  - A free-running 4-bit PWM counter counts 0..14 and wraps; it does not depend on en.
  - leds[i] = (level[i] > pwm).
  - Result: level 15 is always on and level 0 is always off.
- Not defined: the level registers and PWM counter are absent, and leds is one-hot as described above.
- pos, dir, step and the port list are identical in both builds.

## Structure
- Shared package/header `led_scanner_pkg`:
  - Mode encodings MODE_BOUNCE, MODE_ROT_UP, MODE_ROT_DOWN, MODE_HOLD.
  - Trail constants LEVEL_W=4, LEVEL_MAX=15.
- Sub-module `tick_divider`:
  - Parameter PRESCALE; inputs clk, rst, en; output tick.
  - Contains the prescaler only, and is reusable by other blinky-style blocks.
- The position/direction FSM and the trail/PWM logic stay in `led_scanner`.

## Test plan
All scenarios use WIDTH=4 and PRESCALE=4 unless stated otherwise.
- Reset release with en=1, mode=BOUNCE → step at cycle 4, 8, 12, …. pos sequence 0,1,2,3,2,1,0,1; dir falls when pos goes 3→2 and rises when pos goes 0→1; leds one-hot matches pos.
- mode=ROT_UP from pos=3 → pos 0. mode=ROT_DOWN from pos=0 → pos 3. mode=HOLD → pos constant while step keeps pulsing every 4 cycles.
- en=0 for 3 cycles when cnt=2 → next step is delayed by exactly 3 cycles and pos is unchanged meanwhile.
- Mode changed from BOUNCE to ROT_UP one cycle before a step → that step uses ROT_UP. A change on the cycle after a step has no effect until the following step.
- rst pulsed 1 cycle with pos=2, dir=0 → next cycle shows pos=0, dir=1, leds=4'b0001, and the first step comes 4 cycles after reset release. Also run with PRESCALE=1: step is continuously high.
- `LED_SCANNER_TRAIL_EN`, after steps to pos 0,1,2 → levels {3,7,15,0} for indices 0..3.
  - Over one 15-cycle PWM period, LED 2 is on 15 cycles, LED 1 on 7, LED 0 on 3, LED 3 on 0.

Source files
------------

// File: rtl/led_scanner_pkg.sv
// Shared types and constants for the LED scanner and its helpers.
// Mode encodings plus the trail level range used when LED_SCANNER_TRAIL_EN is set.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE   = 2'd0,
        MODE_ROT_UP   = 2'd1,
        MODE_ROT_DOWN = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    localparam int                  LEVEL_W   = 4;
    localparam logic [LEVEL_W-1:0]  LEVEL_MAX = 4'd15;
    localparam logic [LEVEL_W-1:0]  PWM_TOP   = 4'd14;

endpackage

// File: rtl/tick_divider.sv
// Enable-gated prescaler: pulses tick once every PRESCALE enabled cycles.
// Reusable by any blinky-style block that needs a slow strobe.
module tick_divider #(
    parameter int PRESCALE = 300000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int              CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic          w_zero;

    assign w_zero = (r_cnt == '0);
    assign tick   = en && !rst && w_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= RELOAD;
        end else if (en) begin
            r_cnt <= w_zero ? RELOAD : r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/led_scanner.sv
// Moving single-lit LED scanner with bounce, rotate and hold modes.
// Define LED_SCANNER_TRAIL_EN for a PWM-rendered fading trail behind the lit LED.
module led_scanner
    import led_scanner_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 300000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    output logic [WIDTH-1:0]           leds,
    output logic [$clog2(WIDTH)-1:0]   pos,
    output logic                       dir,
    output logic                       step
);

    localparam int             PW   = $clog2(WIDTH);
    localparam logic [PW-1:0]  LAST = PW'(WIDTH - 1);

    logic          w_step;
    logic [PW-1:0] r_pos;
    logic          r_dir;
    logic [PW-1:0] w_pos_nxt;
    logic          w_dir_nxt;

    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos <= '0;
            r_dir <= 1'b1;
        end else begin
            r_pos <= w_pos_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        if (w_step) begin
            unique case (mode_e'(mode))
                MODE_BOUNCE: begin
                    // Turn around at the ends so each end is lit for one step only.
                    if (r_dir) begin
                        if (r_pos == LAST) begin
                            w_dir_nxt = 1'b0;
                            w_pos_nxt = LAST - PW'(1);
                        end else begin
                            w_pos_nxt = r_pos + PW'(1);
                        end
                    end else begin
                        if (r_pos == '0) begin
                            w_dir_nxt = 1'b1;
                            w_pos_nxt = PW'(1);
                        end else begin
                            w_pos_nxt = r_pos - PW'(1);
                        end
                    end
                end
                MODE_ROT_UP: begin
                    w_pos_nxt = (r_pos == LAST) ? '0 : r_pos + PW'(1);
                end
                MODE_ROT_DOWN: begin
                    w_pos_nxt = (r_pos == '0) ? LAST : r_pos - PW'(1);
                end
                MODE_HOLD: begin
                    w_pos_nxt = r_pos;
                end
            endcase
        end
    end

    assign pos  = r_pos;
    assign dir  = r_dir;
    assign step = w_step;

`ifdef LED_SCANNER_TRAIL_EN
    logic [LEVEL_W-1:0] r_level [WIDTH];
    logic [LEVEL_W-1:0] r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_level[i] <= (i == 0) ? LEVEL_MAX : '0;
            end
        end else begin
            r_pwm <= (r_pwm == PWM_TOP) ? '0 : r_pwm + LEVEL_W'(1);
            if (w_step) begin
                for (int i = 0; i < WIDTH; i++) begin
                    r_level[i] <= (PW'(i) == w_pos_nxt) ? LEVEL_MAX
                                                        : (r_level[i] >> 1);
                end
            end
        end
    end

    always_comb begin
        leds = '0;
        for (int i = 0; i < WIDTH; i++) begin
            leds[i] = (r_level[i] > r_pwm);
        end
    end
`else
    always_comb begin
        leds        = '0;
        leds[r_pos] = 1'b1;
    end
`endif

endmodule
